// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control sequencer with memory wait timeout
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
);
    localparam logic [3:0] S_INIT = 4'd0,  S_IF  = 4'd1,  S_ID  = 4'd2,  S_MA  = 4'd3,
                           S_MR   = 4'd4,  S_WBL = 4'd5,  S_MW  = 4'd6,  S_EXR = 4'd7,
                           S_WBR  = 4'd8,  S_BR  = 4'd9,  S_JMP = 4'd10, S_EXI = 4'd11,
                           S_WBI  = 4'd12, S_ILL = 4'd13, S_ERR = 4'd14;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // The wait cycle that would make the count reach MEM_TIMEOUT is the last one tolerated.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [3:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              timeout;

    assign mem_wait = (state == S_IF) || (state == S_MR) || (state == S_MW);
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_INIT;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (mem_wait && !mem_ready && (state_next == state))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT: state_next = S_IF;
            S_IF:   if (mem_ready) state_next = S_ID;
            S_ID: begin
                case (opcode)
                    OP_R:         state_next = S_EXR;
                    OP_LW, OP_SW: state_next = S_MA;
                    OP_BEQ:       state_next = S_BR;
                    OP_J:         state_next = S_JMP;
                    OP_ADDI:      state_next = S_EXI;
                    default:      state_next = S_ILL;
                endcase
            end
            S_MA:   state_next = (opcode == OP_LW) ? S_MR : S_MW;
            S_MR:   if (mem_ready) state_next = S_WBL;
            S_MW:   if (mem_ready) state_next = S_IF;
            S_EXR:  state_next = S_WBR;
            S_EXI:  state_next = S_WBI;
            S_WBR, S_WBL, S_WBI, S_BR, S_JMP, S_ILL: state_next = S_IF;
            S_ERR:  state_next = S_ERR;
            default: state_next = S_INIT;
        endcase
        if (timeout)
            state_next = S_ERR;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        bus_err     = 1'b0;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_ID: ALUSrcB = 2'b11;
            S_MA, S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MR: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MW: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WBL: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_WBR: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_WBI: RegWrite = 1'b1;
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ILL: illegal_op = 1'b1;
            // ERR is absorbing, so decoding the flag from the state keeps it sticky.
            S_ERR: bus_err = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    logic             retire;

    assign retire = (state_next == S_IF) &&
                    ((state == S_WBR) || (state == S_WBL) || (state == S_WBI) ||
                     (state == S_MW)  || (state == S_BR)  || (state == S_JMP));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state != S_ERR)
                cycle_q <= cycle_q + CNT_W'(1);
            if (retire)
                instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the teaching MIPS CPU datapath: PC, IR, register file, ALU, and a single shared instruction/data memory.
- Decodes the 6-bit opcode latched in IR and steps the datapath through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select and write enable.
- Handles memory wait states, memory timeout and illegal opcodes.

Parameters:
OPCODE_W, 6, opcode field width
MEM_TIMEOUT, 15, max consecutive cycles with mem_ready=0 in one memory state before bus error
CNT_W, 32, width of performance counters

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
opcode  input  OPCODE_W  IR[31:26]
mem_ready  input  1  memory completes the access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero
IorD  output  1  0=PC addr, 1=ALUOut addr
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load
MemtoReg  output  1  1=MDR to regfile
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  regfile write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on unknown opcode
bus_err  output  1  sticky memory timeout flag
state  output  4  current state (debug)
cycle_cnt  output  CNT_W  see Optional Feature
instr_cnt  output  CNT_W  see Optional Feature

Behaviour:
- Reset=0 at a Clock edge: state=INIT, wait counter=0, bus_err=0. All outputs are Moore-decoded from state; all are 0 in INIT.
- State encodings:
  - INIT=0, IF=1, ID=2, MA=3, MR=4, WBL=5, MW=6, EXR=7, WBR=8, BR=9, JMP=10, EXI=11, WBI=12, ILL=13, ERR=14.
- State transitions:
  - INIT -> IF.
  - IF -> ID when mem_ready=1, else stay in IF.
  - ID dispatches on opcode:
    - 000000 -> EXR
    - 100011 (lw) or 101011 (sw) -> MA
    - 000100 -> BR
    - 000010 -> JMP
    - 001000 -> EXI
    - any other opcode -> ILL
  - MA -> MR (lw) or MW (sw).
  - MR -> WBL when mem_ready=1.
  - MW -> IF when mem_ready=1.
  - EXR -> WBR. EXI -> WBI.
  - WBR, WBL, WBI, BR, JMP, ILL -> IF.
  - ERR is absorbing until reset.
- Control values per state (unlisted outputs are 0):
  - IF: MemRead=1, ALUSrcB=01. PCWrite and IRWrite are asserted only when mem_ready=1 (Mealy gating on mem_ready only).
  - ID: ALUSrcB=11.
  - MA, EXI: ALUSrcA=1, ALUSrcB=10.
  - MR: MemRead=1, IorD=1.
  - MW: MemWrite=1, IorD=1, held until mem_ready=1.
  - WBL: RegWrite=1, MemtoReg=1.
  - EXR: ALUSrcA=1, ALUOp=10.
  - WBR: RegWrite=1, RegDst=1.
  - WBI: RegWrite=1.
  - BR: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JMP: PCWrite=1, PCSource=10.
  - ILL: illegal_op=1. No PC, register or memory write; the PC already advanced in IF, so the illegal instruction is skipped.
- Latency with mem_ready always 1:
  - R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3, illegal 3.
- Memory wait counter:
  - Counts consecutive cycles in IF/MR/MW with mem_ready=0. Clears on mem_ready=1 or on leaving the state.
  - On reaching MEM_TIMEOUT with mem_ready still 0: next state=ERR, bus_err=1. No strobes are asserted in ERR.
- mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT: mem_ready wins and the access completes normally.
- Reset asserted mid-instruction, including during a wait: returns to INIT next edge. Partial writes are not replayed.
- opcode is sampled only in ID and MA; changes in other states are ignored.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle Reset=1 and state!=ERR.
  - instr_cnt increments on each transition into IF from WBR, WBL, WBI, MW, BR or JMP. ILL does not count.
  - Both counters wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset low 2 cycles, then high with mem_ready=1 and opcode=000000 -> state 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. With PERF: instr_cnt=1, cycle_cnt=5.
- lw (100011) with mem_ready low for 3 cycles in MR -> MR held 4 cycles with MemRead=1 and IorD=1 throughout, then WBL with MemtoReg=1 and RegWrite=1. Total 8 cycles.
- beq (000100) -> IF, ID, BR. In BR: PCWriteCond=1, PCSource=01, ALUOp=01. Next state IF.
- opcode=111111 -> ILL for 1 cycle with illegal_op=1 and all write enables 0, then IF. instr_cnt unchanged.
- sw with mem_ready held 0 -> after 15 wait cycles state=14 and bus_err=1. MemWrite=0 from then on. Stays in ERR until Reset=0.
- Reset=0 asserted while in MW -> next state=0 with all outputs 0. bus_err cleared, counters cleared.
